// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//   Load/store unit for the MEM stage of a 5-stage RISC-V style pipeline.
//   Turns the EX/MEM load/store fields into a single request on a simple
//   request/ready + rvalid data bus, stalls the front of the pipeline while
//   the access is in flight, and returns the aligned, sign/zero-extended load
//   result. Accesses that stay in REQ+RESP for TIMEOUT_CYCLES are abandoned
//   and reported with a one-cycle bus-error pulse.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_mem_read_en       load in MEM stage (wins over write_en)
//   mem_mem_write_en      store in MEM stage
//   mem_funct3            access size/sign (B/H/W/BU/HU; 011/110/111 act as W)
//   mem_alu_result        byte address
//   mem_rs2_data          store data
//   dbus_req/we/addr/
//   wdata/be              registered bus request, held stable until accepted
//   dbus_ready            request accepted this cycle
//   dbus_rvalid/rdata     read data return (only looked at while in RESP)
//   lsu_stall             freeze IF..EX/MEM registers
//   lsu_load_data         last completed load result
//   lsu_misaligned        combinational misaligned-access flag
//   lsu_bus_err           one-cycle timeout pulse
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_mem_read_en,
   input  logic        mem_mem_write_en,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_rs2_data,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   input  logic        dbus_ready,
   input  logic        dbus_rvalid,
   input  logic [31:0] dbus_rdata,
   output logic        lsu_stall,
   output logic [31:0] lsu_load_data,
   output logic        lsu_misaligned,
   output logic        lsu_bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Counter value seen in the last allowed REQ/RESP cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // Access decode helpers
   // ---------------------------------------------------------------------------
   // 0 = byte, 1 = halfword, 2 = word
   function automatic logic [1:0] size_of(input logic [2:0] f3);
      if (f3[1])      return 2'd2;
      else if (f3[0]) return 2'd1;
      else            return 2'd0;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (size_of(f3))
         2'd1:    return a[0];
         2'd2:    return |a;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] be_of(input logic ld, input logic [2:0] f3,
                                        input logic [1:0] a);
      if (ld) return 4'b1111;
      case (size_of(f3))
         2'd0:    return 4'b0001 << a;
         2'd1:    return 4'b0011 << a;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
      case (size_of(f3))
         2'd0:    return {4{d[7:0]}};
         2'd1:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // f3[2] selects zero extension (BU/HU); for word sizes it has no effect.
   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      case (a)
         2'd0:    lane_b = d[7:0];
         2'd1:    lane_b = d[15:8];
         2'd2:    lane_b = d[23:16];
         default: lane_b = d[31:24];
      endcase
      lane_h = a[1] ? d[31:16] : d[15:0];
      case (size_of(f3))
         2'd0:    return f3[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'd1:    return f3[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: return d;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_load_data;
   logic        r_bus_err;
   logic        r_is_load;
   logic [2:0]  r_funct3;
   logic [1:0]  r_addr_lo;

   logic w_access;
   logic w_mis;
   logic w_idle;
   logic w_start;
   logic w_timeout;

   assign w_access  = mem_mem_read_en | mem_mem_write_en;
   assign w_mis     = is_misaligned(mem_funct3, mem_alu_result[1:0]);
   assign w_idle    = (r_state == ST_IDLE);
   // rst_n gating keeps the combinational outputs low while reset is held.
   assign w_start   = rst_n & w_idle & w_access & ~w_mis;
   assign w_timeout = (r_cnt >= TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_load_data <= '0;
         r_bus_err   <= 1'b0;
         r_is_load   <= 1'b0;
         r_funct3    <= '0;
         r_addr_lo   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_bus_err <= 1'b0;
               if (w_start) begin
                  r_state   <= ST_REQ;
                  r_req     <= 1'b1;
                  r_we      <= ~mem_mem_read_en;
                  r_addr    <= {mem_alu_result[31:2], 2'b00};
                  r_be      <= be_of(mem_mem_read_en, mem_funct3, mem_alu_result[1:0]);
                  r_wdata   <= wdata_of(mem_funct3, mem_rs2_data);
                  r_is_load <= mem_mem_read_en;
                  r_funct3  <= mem_funct3;
                  r_addr_lo <= mem_alu_result[1:0];
                  r_cnt     <= '0;
               end
            end
            // Handshake is tested before the timeout so a late accept still wins.
            ST_REQ: begin
               if (dbus_ready) begin
                  r_req   <= 1'b0;
                  r_cnt   <= r_cnt + 8'd1;
                  r_state <= r_is_load ? ST_RESP : ST_DONE;
               end else if (w_timeout) begin
                  r_req     <= 1'b0;
                  r_state   <= ST_DONE;
                  r_bus_err <= 1'b1;
                  if (r_is_load) r_load_data <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               if (dbus_rvalid) begin
                  r_load_data <= load_extract(r_funct3, r_addr_lo, dbus_rdata);
                  r_state     <= ST_DONE;
               end else if (w_timeout) begin
                  r_load_data <= '0;
                  r_bus_err   <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            // One unstalled cycle lets the pipeline advance past this access.
            ST_DONE: begin
               r_bus_err <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dbus_req       = r_req;
   assign dbus_we        = r_we;
   assign dbus_addr      = r_addr;
   assign dbus_wdata     = r_wdata;
   assign dbus_be        = r_be;
   assign lsu_load_data  = r_load_data;
   assign lsu_bus_err    = r_bus_err;
   assign lsu_misaligned = rst_n & w_idle & w_access & w_mis;
   assign lsu_stall      = w_start | (r_state == ST_REQ) | (r_state == ST_RESP);

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

   localparam int T = 8;
   localparam int NEVER = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_mem_read_en;
   logic        mem_mem_write_en;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_rs2_data;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_ready;
   logic        dbus_rvalid;
   logic [31:0] dbus_rdata;
   logic        lsu_stall;
   logic [31:0] lsu_load_data;
   logic        lsu_misaligned;
   logic        lsu_bus_err;

   mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .mem_mem_read_en  (mem_mem_read_en),
      .mem_mem_write_en (mem_mem_write_en),
      .mem_funct3       (mem_funct3),
      .mem_alu_result   (mem_alu_result),
      .mem_rs2_data     (mem_rs2_data),
      .dbus_req         (dbus_req),
      .dbus_we          (dbus_we),
      .dbus_addr        (dbus_addr),
      .dbus_wdata       (dbus_wdata),
      .dbus_be          (dbus_be),
      .dbus_ready       (dbus_ready),
      .dbus_rvalid      (dbus_rvalid),
      .dbus_rdata       (dbus_rdata),
      .lsu_stall        (lsu_stall),
      .lsu_load_data    (lsu_load_data),
      .lsu_misaligned   (lsu_misaligned),
      .lsu_bus_err      (lsu_bus_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] model_ld = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int sz_of(input logic [2:0] f3);
      if (f3[1]) return 4;
      if (f3[0]) return 2;
      return 1;
   endfunction

   function automatic logic [31:0] exp_extract(input logic [2:0] f3, input int a,
                                               input logic [31:0] rd);
      logic [31:0] v;
      int s;
      s = sz_of(f3);
      if (s == 4) return rd;
      if (s == 1) begin
         v = (rd >> (8 * a)) & 32'hFF;
         if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else begin
         v = (rd >> (16 * (a / 2))) & 32'hFFFF;
         if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   // One access from presentation in IDLE through its DONE cycle.
   // r  = REQ cycle (1-based) in which the bus accepts, NEVER for no accept.
   // rv = RESP cycle (1-based) carrying rvalid, NEVER for no data.
   task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [31:0] rdv, input int r, input int rv);
      int s, a, req_cycles, busy, v;
      bit mis, err, in_req;
      logic [31:0] exp_be, exp_wd, ld_new;
      s   = sz_of(f3);
      a   = int'(addr[1:0]);
      mis = (a % s) != 0;
      @(negedge clk);
      mem_mem_read_en  = rd;
      mem_mem_write_en = wr;
      mem_funct3       = f3;
      mem_alu_result   = addr;
      mem_rs2_data     = rs2;
      dbus_ready       = 1'b0;
      dbus_rvalid      = 1'b0;
      #1;
      check_eq("misaligned_flag", 32'(lsu_misaligned), 32'(mis));
      check_eq("stall_present", 32'(lsu_stall), 32'(!mis));
      check_eq("req_present", 32'(dbus_req), 0);
      check_eq("err_present", 32'(lsu_bus_err), 0);
      check_eq("load_data_hold", lsu_load_data, model_ld);
      if (mis) return;

      req_cycles = (r <= T) ? r : T;
      err        = (r > T);
      busy       = req_cycles;
      ld_new     = model_ld;
      v          = 0;
      if (rd) begin
         if (err) ld_new = '0;
         else begin
            v = r + rv;
            if (v <= T) begin
               busy   = v;
               ld_new = exp_extract(f3, a, rdv);
            end else begin
               busy   = T;
               err    = 1'b1;
               ld_new = '0;
            end
         end
      end
      if (rd)          exp_be = 32'hF;
      else if (s == 1) exp_be = 32'(1 << a);
      else if (s == 2) exp_be = 32'(3 << a);
      else             exp_be = 32'hF;
      if (s == 1)      exp_wd = (rs2 & 32'hFF) * 32'h0101_0101;
      else if (s == 2) exp_wd = (rs2 & 32'hFFFF) * 32'h0001_0001;
      else             exp_wd = rs2;

      for (int k = 1; k <= busy; k++) begin
         @(negedge clk);
         in_req = (k <= req_cycles);
         if (in_req) begin
            dbus_ready  = (k == r);
            dbus_rvalid = 1'($urandom_range(0, 1));   // must be ignored in REQ
            dbus_rdata  = $urandom;
         end else begin
            dbus_ready  = 1'($urandom_range(0, 1));   // must be ignored in RESP
            dbus_rvalid = (k == v);
            dbus_rdata  = (k == v) ? rdv : $urandom;
         end
         #1;
         check_eq("stall_busy", 32'(lsu_stall), 1);
         check_eq("req_busy", 32'(dbus_req), 32'(in_req));
         if (in_req) begin
            check_eq("bus_addr", dbus_addr, addr & 32'hFFFF_FFFC);
            check_eq("bus_we", 32'(dbus_we), 32'(!rd));
            check_eq("bus_be", 32'(dbus_be), exp_be);
            if (!rd) check_eq("bus_wdata", dbus_wdata, exp_wd);
         end
      end

      @(negedge clk);
      dbus_ready  = 1'($urandom_range(0, 1));
      dbus_rvalid = 1'($urandom_range(0, 1));
      dbus_rdata  = $urandom;
      #1;
      check_eq("stall_done", 32'(lsu_stall), 0);
      check_eq("req_done", 32'(dbus_req), 0);
      check_eq("err_done", 32'(lsu_bus_err), 32'(err));
      check_eq("load_data_done", lsu_load_data, ld_new);
      model_ld = ld_new;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      mem_mem_read_en  = 1'b0;
      mem_mem_write_en = 1'b0;
      mem_alu_result   = $urandom;
      dbus_ready       = 1'($urandom_range(0, 1));
      dbus_rvalid      = 1'($urandom_range(0, 1));
      dbus_rdata       = $urandom;
      #1;
      check_eq("stall_idle", 32'(lsu_stall), 0);
      check_eq("req_idle", 32'(dbus_req), 0);
      check_eq("mis_idle", 32'(lsu_misaligned), 0);
      check_eq("load_data_idle", lsu_load_data, model_ld);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, time=%0t", $time);
      $fatal(1);
   end

   initial begin
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] addr;
      int r, rv, s;

      // Reset with an aligned load presented: everything must stay low.
      rst_n            = 1'b0;
      mem_mem_read_en  = 1'b1;
      mem_mem_write_en = 1'b0;
      mem_funct3       = 3'b010;
      mem_alu_result   = 32'h10;
      mem_rs2_data     = 32'h0;
      dbus_ready       = 1'b0;
      dbus_rvalid      = 1'b0;
      dbus_rdata       = 32'h0;
      #3;
      check_eq("rst_stall", 32'(lsu_stall), 0);
      check_eq("rst_req", 32'(dbus_req), 0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ld", lsu_load_data, 0);
      check_eq("rst_err", 32'(lsu_bus_err), 0);
      check_eq("rst_addr", dbus_addr, 0);
      check_eq("rst_be", 32'(dbus_be), 0);
      check_eq("rst_wdata", dbus_wdata, 0);
      check_eq("rst_we", 32'(dbus_we), 0);
      @(negedge clk);
      mem_mem_read_en = 1'b0;
      rst_n           = 1'b1;

      // Directed cases
      do_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 3, 1);
      do_access(1, 0, 3'b000, 32'h203, 0, 32'h80FF_FF7F, 1, 1);
      do_access(1, 0, 3'b100, 32'h203, 0, 32'h80FF_FF7F, 1, 1);
      do_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 1, 1);
      do_access(1, 0, 3'b010, 32'h101, 0, 0, 1, 1);
      do_access(1, 0, 3'b010, 32'h400, 0, 32'h1234_5678, 1, NEVER);
      do_access(1, 0, 3'b010, 32'h500, 0, 32'hCAFE_F00D, 1, 1);
      do_access(0, 1, 3'b010, 32'h504, 32'h55AA_55AA, 0, 1, 1);
      do_access(0, 1, 3'b010, 32'h600, 32'h0000_0001, 0, T, 1);
      do_access(1, 0, 3'b101, 32'h702, 0, 32'hBEEF_1234, 4, 4);
      do_access(1, 1, 3'b001, 32'h802, 32'hFFFF_FFFF, 32'h8001_7FFF, 2, 2);
      do_access(0, 1, 3'b000, 32'h901, 32'h0000_00AB, 0, NEVER, 1);
      do_access(1, 0, 3'b110, 32'hA04, 0, 32'h1357_9BDF, 1, 2);

      // Reset while in REQ: request must drop without a clock edge.
      @(negedge clk);
      mem_mem_read_en  = 1'b0;
      mem_mem_write_en = 1'b1;
      mem_funct3       = 3'b010;
      mem_alu_result   = 32'hA00;
      mem_rs2_data     = 32'h0BAD_F00D;
      dbus_ready       = 1'b0;
      dbus_rvalid      = 1'b0;
      @(negedge clk);
      #1;
      check_eq("req_before_rst", 32'(dbus_req), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_req_async", 32'(dbus_req), 0);
      check_eq("rst_stall_async", 32'(lsu_stall), 0);
      check_eq("rst_ld_async", lsu_load_data, 0);
      model_ld = '0;
      @(negedge clk);
      mem_mem_write_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while in RESP: a later rvalid must not produce a completion.
      do_access(1, 0, 3'b010, 32'hB10, 0, 32'h2468_ACE0, 1, 1);
      @(negedge clk);
      mem_mem_read_en = 1'b1;
      mem_funct3      = 3'b010;
      mem_alu_result  = 32'hB00;
      dbus_ready      = 1'b0;
      dbus_rvalid     = 1'b0;
      @(negedge clk);
      dbus_ready = 1'b1;
      @(negedge clk);
      dbus_ready = 1'b0;
      #1;
      check_eq("stall_resp_pre_rst", 32'(lsu_stall), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_resp_req", 32'(dbus_req), 0);
      check_eq("rst_resp_stall", 32'(lsu_stall), 0);
      check_eq("rst_resp_ld", lsu_load_data, 0);
      model_ld = '0;
      @(negedge clk);
      mem_mem_read_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dbus_rvalid = 1'b1;
         dbus_rdata  = $urandom | 32'h1;
         #1;
         check_eq("post_rst_ld", lsu_load_data, 0);
         check_eq("post_rst_stall", 32'(lsu_stall), 0);
         check_eq("post_rst_err", 32'(lsu_bus_err), 0);
      end
      dbus_rvalid = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         rd   = 1'($urandom_range(0, 1));
         wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         f3   = 3'($urandom_range(0, 7));
         addr = $urandom;
         s    = sz_of(f3);
         if ($urandom_range(0, 3) != 0) addr = addr & ~32'(s - 1);
         r    = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 4));
         rv   = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 4));
         do_access(rd, wr, f3, addr, $urandom, $urandom, r, rv);
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end
      idle_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+RESP before the access is abandoned.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 mem_mem_read_en  in  1  load in MEM stage (EX/MEM register output).
REQ-005 mem_mem_write_en  in  1  store in MEM stage.
REQ-006 mem_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 mem_alu_result  in  32  byte address.
REQ-008 mem_rs2_data  in  32  store data.
REQ-009 dbus_req  out  1  bus request, held until accepted.
REQ-010 dbus_we  out  1  1 = write.
REQ-011 dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-012 dbus_wdata  out  32  lane-replicated store data.
REQ-013 dbus_be  out  4  byte enables.
REQ-014 dbus_ready  in  1  request accepted this cycle.
REQ-015 dbus_rvalid  in  1  read data valid.
REQ-016 dbus_rdata  in  32  read data word.
REQ-017 lsu_stall  out  1  freeze IF..EX/MEM registers.
REQ-018 lsu_load_data  out  32  aligned, extended load result.
REQ-019 lsu_misaligned  out  1  combinational misaligned-access flag.
REQ-020 lsu_bus_err  out  1  one-cycle timeout pulse.

Function
REQ-021 FSM states IDLE, REQ, RESP, DONE; exactly one active.
REQ-022 access = read_en | write_en; read_en and write_en both set: load, write ignored.
REQ-023 misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0; funct3 011/110/111 treated as W.
REQ-024 IDLE, access, misaligned: lsu_misaligned=1, no request, no stall, remain IDLE.
REQ-025 IDLE, access, aligned: lsu_stall=1 same cycle (combinational); next edge -> REQ with dbus_addr/we/be/wdata registered.
REQ-026 REQ: dbus_req=1, bus outputs stable; on dbus_ready store -> DONE, load -> RESP.
REQ-027 dbus_rvalid ignored outside RESP.
REQ-028 RESP: on dbus_rvalid capture extracted data into lsu_load_data, -> DONE.
REQ-029 DONE: lsu_stall=0 for exactly one cycle, dbus_req=0; next edge -> IDLE regardless of inputs.
REQ-030 lsu_stall=1 in REQ and RESP.
REQ-031 Byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111; loads 4'b1111.
REQ-032 wdata: B {4{rs2[7:0]}}; H {2{rs2[15:0]}}; W rs2.
REQ-033 Load extract: B/BU byte lane addr[1:0], H/HU halfword lane addr[1]; B/H sign-extend, BU/HU zero-extend.
REQ-034 lsu_load_data held until next completed load; stores and misaligned accesses leave it unchanged.
REQ-035 8-bit timeout counter cleared on entry to REQ, increments each REQ/RESP cycle; reaching TIMEOUT_CYCLES -> DONE, lsu_bus_err=1 during DONE, lsu_load_data=0 for loads.
REQ-036 dbus_ready/rvalid arriving the same cycle as timeout: handshake wins, no error.

Reset
REQ-037 rst_n low: state IDLE immediately, all outputs 0 (dbus_*, lsu_stall, lsu_load_data, lsu_bus_err), counter 0.
REQ-038 Reset mid-access (REQ/RESP): dbus_req drops without waiting for an edge; no completion produced after release.
REQ-039 First access examined on the first rising edge after rst_n rises.

Verification
REQ-040 SW addr 0x100, rs2 0xDEADBEEF, ready after 2 cycles -> dbus_be 1111, wdata 0xDEADBEEF, stall 3 cycles, then DONE.
REQ-041 LB addr 0x203, rdata 0x80FF_FF7F, rvalid 1 cycle after accept -> lsu_load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-042 SH addr 0x102 rs2 0x1234ABCD -> be 1100, wdata 0xABCDABCD; LW addr 0x101 -> lsu_misaligned=1, dbus_req=0, stall=0.
REQ-043 Load, ready given, rvalid never asserted, TIMEOUT_CYCLES=8 -> DONE after 8 cycles, lsu_bus_err one-cycle pulse, lsu_load_data 0.
REQ-044 rst_n low while in RESP -> dbus_req/lsu_stall 0 asynchronously, later rvalid ignored, lsu_load_data 0.
REQ-045 Back-to-back LW then SW (both ready immediately) -> exactly one DONE cycle between accesses, two distinct bus requests.
